gesture_classifier: RTL and testbench

Parametrised successor to the single-cycle threshold gesture decoder. Per axis, it filters the ADXL345 samples with a moving average and classifies them with hysteresis. A new gesture is committed only after it has been stable for a number of consecutive samples, and each committed change is emitted as one ASCII byte through a valid/ready handshake. It sits between the ADXL345 SPI reader (sample strobe plus signed X/Y/Z) and the UART transmitter.

---
 rtl/gesture_pkg.sv | 42 ++++
 rtl/axis_moving_avg.sv | 56 +++++
 rtl/gesture_classifier.sv | 187 ++++++++++++++++++
 tb/tb_gesture_classifier.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared definitions for the gesture classifier: ASCII event codes and the
// mapping from a gesture code to the axis/bound direction used for hysteresis.
package gesture_pkg;

    localparam logic [7:0] ASCII_N    = 8'h6E;
    localparam logic [7:0] ASCII_F    = 8'h66;
    localparam logic [7:0] ASCII_B    = 8'h62;
    localparam logic [7:0] ASCII_R    = 8'h72;
    localparam logic [7:0] ASCII_L    = 8'h6C;
    localparam logic [7:0] ASCII_S    = 8'h73;
    localparam logic [7:0] ASCII_IDLE = 8'h3B;

    typedef enum logic [1:0] {
        AXIS_X = 2'd0,
        AXIS_Y = 2'd1,
        AXIS_Z = 2'd2
    } axis_e;

    // upper = 1: gesture fires when the axis is above its bound (relax by lowering it)
    // upper = 0: gesture fires when the axis is below its bound (relax by raising it)
    typedef struct packed {
        axis_e axis;
        logic  upper;
    } hyst_map_t;

    function automatic hyst_map_t gesture_hyst_map(input logic [7:0] code);
        hyst_map_t m;
        m.axis  = AXIS_X;
        m.upper = 1'b1;
        case (code)
            ASCII_S: begin m.axis = AXIS_Z; m.upper = 1'b0; end
            ASCII_N: begin m.axis = AXIS_X; m.upper = 1'b1; end
            ASCII_F: begin m.axis = AXIS_X; m.upper = 1'b1; end
            ASCII_B: begin m.axis = AXIS_X; m.upper = 1'b0; end
            ASCII_R: begin m.axis = AXIS_Y; m.upper = 1'b1; end
            ASCII_L: begin m.axis = AXIS_Y; m.upper = 1'b0; end
            default: begin m.axis = AXIS_X; m.upper = 1'b1; end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/axis_moving_avg.sv
// Per-axis moving average over 2^AVG_LOG2 samples with a running sum.
// Ports: clk, r_rstn (sync, active-low), sample_valid strobe, din (signed
// sample), avg (registered signed average, updated on the strobe edge).
module axis_moving_avg
    import gesture_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             r_rstn,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] avg
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SW    = WIDTH + AVG_LOG2;

    logic [WIDTH-1:0]     hist_q [DEPTH];
    logic [WIDTH-1:0]     hist_d [DEPTH];
    logic signed [SW-1:0] sum_q, sum_d;
    logic [WIDTH-1:0]     avg_q, avg_d;

    // Shift history, update running sum, derive the average from the new sum
    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        avg_d  = avg_q;
        if (sample_valid) begin
            hist_d[0] = din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            sum_d = sum_q + SW'($signed(din)) - SW'($signed(hist_q[DEPTH-1]));
            avg_d = WIDTH'(sum_d >>> AVG_LOG2);
        end
    end

    always_ff @(posedge clk) begin
        if (!r_rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q <= '0;
            avg_q <= '0;
        end else begin
            hist_q <= hist_d;
            sum_q  <= sum_d;
            avg_q  <= avg_d;
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/gesture_classifier.sv
// Accelerometer gesture classifier: filters X/Y/Z, classifies with priority
// and hysteresis, debounces, and emits each committed change as one ASCII
// byte over a valid/ready handshake.
// Ports: clk, r_rstn (sync, active-low), sample_valid + x/y/z_axis_datain
// (signed samples), gesture_ready (sink accept), gesture_data (event byte),
// gesture_valid (event pending), gesture_level (committed gesture),
// overflow (sticky: pending event overwritten).
module gesture_classifier
    import gesture_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned HOLD_CNT  = 3,
    parameter int          NITRO_TH  = 150,
    parameter int          XY_TH     = 80,
    parameter int          Z_FLIP_TH = -200,
    parameter int          HYST      = 16
) (
    input  logic             clk,
    input  logic             r_rstn,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] x_axis_datain,
    input  logic [WIDTH-1:0] y_axis_datain,
    input  logic [WIDTH-1:0] z_axis_datain,
    input  logic             gesture_ready,
    output logic [7:0]       gesture_data,
    output logic             gesture_valid,
    output logic [7:0]       gesture_level,
    output logic             overflow
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned FW    = $clog2(DEPTH + 1);
    localparam int unsigned HW    = $clog2(HOLD_CNT + 1);
    // Two guard bits so relaxed bounds never wrap
    localparam int unsigned CW    = WIDTH + 2;

    localparam logic signed [CW-1:0] NITRO_C  = CW'($signed(WIDTH'(NITRO_TH)));
    localparam logic signed [CW-1:0] XY_POS_C = CW'($signed(WIDTH'(XY_TH)));
    localparam logic signed [CW-1:0] XY_NEG_C = CW'($signed(WIDTH'(-XY_TH)));
    localparam logic signed [CW-1:0] Z_C      = CW'($signed(WIDTH'(Z_FLIP_TH)));
    localparam logic signed [CW-1:0] HYST_C   = CW'($signed(WIDTH'(HYST)));

    logic [WIDTH-1:0] x_avg, y_avg, z_avg;
    logic signed [CW-1:0] x_ext, y_ext, z_ext;

    logic [FW-1:0] fill_q, fill_d;
    logic          cls_valid_q, cls_valid_d;
    logic [7:0]    cand_q, cand_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    level_q, level_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    cand_c;
    logic          commit_c;

    axis_moving_avg #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk(clk), .r_rstn(r_rstn), .sample_valid(sample_valid),
        .din(x_axis_datain), .avg(x_avg)
    );
    axis_moving_avg #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk(clk), .r_rstn(r_rstn), .sample_valid(sample_valid),
        .din(y_axis_datain), .avg(y_avg)
    );
    axis_moving_avg #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg_z (
        .clk(clk), .r_rstn(r_rstn), .sample_valid(sample_valid),
        .din(z_axis_datain), .avg(z_avg)
    );

    assign x_ext = CW'($signed(x_avg));
    assign y_ext = CW'($signed(y_avg));
    assign z_ext = CW'($signed(z_avg));

    // True when gesture 'code' fires, with its bound relaxed if it is committed
    function automatic logic gesture_hit(
        input logic [7:0]           code,
        input logic [7:0]           level,
        input logic signed [CW-1:0] base,
        input logic signed [CW-1:0] ax,
        input logic signed [CW-1:0] ay,
        input logic signed [CW-1:0] az
    );
        hyst_map_t            m;
        logic signed [CW-1:0] bound;
        logic signed [CW-1:0] val;
        m     = gesture_hyst_map(code);
        bound = base;
        if (code == level) begin
            bound = m.upper ? (base - HYST_C) : (base + HYST_C);
        end
        case (m.axis)
            AXIS_X:  val = ax;
            AXIS_Y:  val = ay;
            default: val = az;
        endcase
        return m.upper ? (val > bound) : (val < bound);
    endfunction

    // Priority classifier on the registered averages
    always_comb begin
        cand_c = ASCII_IDLE;
        if (gesture_hit(ASCII_S, level_q, Z_C, x_ext, y_ext, z_ext)) begin
            cand_c = ASCII_S;
        end else if (gesture_hit(ASCII_N, level_q, NITRO_C, x_ext, y_ext, z_ext)) begin
            cand_c = ASCII_N;
        end else if (gesture_hit(ASCII_F, level_q, XY_POS_C, x_ext, y_ext, z_ext)) begin
            cand_c = ASCII_F;
        end else if (gesture_hit(ASCII_B, level_q, XY_NEG_C, x_ext, y_ext, z_ext)) begin
            cand_c = ASCII_B;
        end else if (gesture_hit(ASCII_R, level_q, XY_POS_C, x_ext, y_ext, z_ext)) begin
            cand_c = ASCII_R;
        end else if (gesture_hit(ASCII_L, level_q, XY_NEG_C, x_ext, y_ext, z_ext)) begin
            cand_c = ASCII_L;
        end
    end

    // Warm-up fill count, debounce, commit and output handshake
    always_comb begin
        fill_d      = fill_q;
        cls_valid_d = sample_valid;
        cand_d      = cand_q;
        hold_d      = hold_q;
        level_d     = level_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        commit_c    = 1'b0;

        if (sample_valid && (fill_q != FW'(DEPTH))) begin
            fill_d = fill_q + FW'(1);
        end

        // fill_q already includes the sample whose average is being classified
        if (cls_valid_q && (fill_q == FW'(DEPTH))) begin
            cand_d = cand_c;
            if (cand_c != cand_q) begin
                hold_d = HW'(1);
            end else if (hold_q != HW'(HOLD_CNT)) begin
                hold_d = hold_q + HW'(1);
            end
            commit_c = (hold_d == HW'(HOLD_CNT)) && (cand_c != level_q);
        end

        if (valid_q && gesture_ready) begin
            valid_d = 1'b0;
        end

        if (commit_c) begin
            level_d = cand_c;
            data_d  = cand_c;
            valid_d = 1'b1;
            // Acceptance in the same cycle frees the slot, so no overflow then
            if (valid_q && !gesture_ready) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!r_rstn) begin
            fill_q      <= '0;
            cls_valid_q <= 1'b0;
            cand_q      <= ASCII_IDLE;
            hold_q      <= '0;
            level_q     <= ASCII_IDLE;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            cls_valid_q <= cls_valid_d;
            cand_q      <= cand_d;
            hold_q      <= hold_d;
            level_q     <= level_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign gesture_data  = data_q;
    assign gesture_valid = valid_q;
    assign gesture_level = level_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_gesture_classifier.sv
// Bench for gesture_classifier: a behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_gesture_classifier;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned AVG_LOG2  = 2;
    localparam int unsigned HOLD_CNT  = 3;
    localparam int          NITRO_TH  = 150;
    localparam int          XY_TH     = 80;
    localparam int          Z_FLIP_TH = -200;
    localparam int          HYST      = 16;
    localparam int          DEPTH     = 1 << AVG_LOG2;

    logic             clk;
    logic             r_rstn;
    logic             sample_valid;
    logic [WIDTH-1:0] x_in, y_in, z_in;
    logic             gesture_ready;
    logic [7:0]       gesture_data;
    logic             gesture_valid;
    logic [7:0]       gesture_level;
    logic             overflow;

    gesture_classifier #(
        .WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .HOLD_CNT(HOLD_CNT),
        .NITRO_TH(NITRO_TH), .XY_TH(XY_TH), .Z_FLIP_TH(Z_FLIP_TH), .HYST(HYST)
    ) dut (
        .clk(clk),
        .r_rstn(r_rstn),
        .sample_valid(sample_valid),
        .x_axis_datain(x_in),
        .y_axis_datain(y_in),
        .z_axis_datain(z_in),
        .gesture_ready(gesture_ready),
        .gesture_data(gesture_data),
        .gesture_valid(gesture_valid),
        .gesture_level(gesture_level),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int hs_cnt = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         qx[$], qy[$], qz[$];
    int         m_fill;
    bit         p_valid, p_full;
    int         p_x, p_y, p_z;
    logic [7:0] m_cand, m_level, m_data, c_new;
    int         m_hold;
    bit         m_valid, m_ovf, was_pending, do_commit;

    function automatic int avg_of(input int q[$]);
        int s;
        s = 0;
        foreach (q[i]) s += q[i];
        return s >>> AVG_LOG2;
    endfunction

    function automatic int rlx(input logic [7:0] g, input logic [7:0] lvl);
        return (g == lvl) ? HYST : 0;
    endfunction

    function automatic logic [7:0] classify(input int ax, input int ay, input int az,
                                            input logic [7:0] lvl);
        if (az < Z_FLIP_TH + rlx(8'h73, lvl)) return 8'h73;
        if (ax > NITRO_TH - rlx(8'h6E, lvl))  return 8'h6E;
        if (ax > XY_TH - rlx(8'h66, lvl))     return 8'h66;
        if (ax < -XY_TH + rlx(8'h62, lvl))    return 8'h62;
        if (ay > XY_TH - rlx(8'h72, lvl))     return 8'h72;
        if (ay < -XY_TH + rlx(8'h6C, lvl))    return 8'h6C;
        return 8'h3B;
    endfunction

    always @(posedge clk) begin
        if (!r_rstn) begin
            qx.delete(); qy.delete(); qz.delete();
            repeat (DEPTH) begin qx.push_back(0); qy.push_back(0); qz.push_back(0); end
            m_fill  = 0;
            p_valid = 1'b0;
            p_full  = 1'b0;
            m_cand  = 8'h3B;
            m_hold  = 0;
            m_level = 8'h3B;
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            was_pending = m_valid && !gesture_ready;
            if (m_valid && gesture_ready) m_valid = 1'b0;
            do_commit = 1'b0;
            if (p_valid && p_full) begin
                c_new = classify(p_x, p_y, p_z, m_level);
                if (c_new != m_cand) m_hold = 1;
                else if (m_hold < HOLD_CNT) m_hold++;
                m_cand = c_new;
                do_commit = (m_hold == HOLD_CNT) && (c_new != m_level);
            end
            if (do_commit) begin
                if (was_pending) m_ovf = 1'b1;
                m_level = c_new;
                m_data  = c_new;
                m_valid = 1'b1;
            end
            p_valid = 1'b0;
            if (sample_valid) begin
                qx.push_back(int'($signed(x_in))); void'(qx.pop_front());
                qy.push_back(int'($signed(y_in))); void'(qy.pop_front());
                qz.push_back(int'($signed(z_in))); void'(qz.pop_front());
                if (m_fill < DEPTH) m_fill++;
                p_x = avg_of(qx);
                p_y = avg_of(qy);
                p_z = avg_of(qz);
                p_full  = (m_fill == DEPTH);
                p_valid = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (r_rstn && gesture_valid && gesture_ready) hs_cnt++;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_data",  gesture_data, m_data);
            check("model_valid", 8'(gesture_valid), 8'(m_valid));
            check("model_level", gesture_level, m_level);
            check("model_ovf",   8'(overflow), 8'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    // Starts and ends on a negedge; gap = cycles from this strobe to the next
    task automatic strobe(input int x, input int y, input int z, input int gap);
        sample_valid = 1'b1;
        x_in = WIDTH'(x);
        y_in = WIDTH'(y);
        z_in = WIDTH'(z);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic strobes(input int n, input int x, input int y, input int z, input int gap);
        for (int i = 0; i < n; i++) strobe(x, y, z, gap);
    endtask

    int hs0;

    initial begin
        r_rstn = 1'b0;
        sample_valid = 1'b0;
        gesture_ready = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(negedge clk);
        r_rstn = 1'b1;
        cmp_en = 1'b1;
        check("reset_data",  gesture_data, 8'h00);
        check("reset_valid", 8'(gesture_valid), 8'h00);
        check("reset_level", gesture_level, 8'h3B);
        check("reset_ovf",   8'(overflow), 8'h00);

        // Warm-up and commit of forward
        strobes(5, 100, 0, 0, 4);
        check("warmup_no_event", 8'(gesture_valid), 8'h00);
        check("warmup_level", gesture_level, 8'h3B);
        strobe(100, 0, 0, 2);
        check("fwd_valid_n2", 8'(gesture_valid), 8'h01);
        check("fwd_data", gesture_data, 8'h66);
        check("fwd_level", gesture_level, 8'h66);
        gesture_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("fwd_accepted", 8'(gesture_valid), 8'h00);

        // Priority: nitro over forward/left, then stop over all
        strobes(6, 200, -120, 0, 4);
        check("nitro_level", gesture_level, 8'h6E);
        strobes(6, 200, -120, -300, 4);
        check("stop_level", gesture_level, 8'h73);
        check("stop_data", gesture_data, 8'h73);

        // Hysteresis around forward
        strobes(8, 100, 0, 0, 4);
        check("hyst_f_level", gesture_level, 8'h66);
        hs0 = hs_cnt;
        strobes(8, 70, 0, 0, 4);
        check("hyst_hold_level", gesture_level, 8'h66);
        check("hyst_no_event", 8'(hs_cnt - hs0), 8'h00);
        strobes(8, 60, 0, 0, 4);
        check("hyst_release", gesture_level, 8'h3B);

        // Glitch rejection: short-lived candidates never reach the hold count
        hs0 = hs_cnt;
        strobes(4, 0, 0, 0, 4);
        strobe(-500, 0, 0, 4);
        strobe(500, 0, 0, 4);
        strobes(6, 0, 0, 0, 4);
        strobe(-300, 0, 0, 4);
        strobes(4, 0, 0, 0, 4);
        check("glitch_level", gesture_level, 8'h3B);
        check("glitch_no_event", 8'(hs_cnt - hs0), 8'h00);

        // Backpressure with overwrite
        gesture_ready = 1'b0;
        strobes(6, 100, 0, 0, 4);
        strobes(8, 0, 100, 0, 4);
        check("bp_data", gesture_data, 8'h72);
        check("bp_ovf", 8'(overflow), 8'h01);
        check("bp_valid", 8'(gesture_valid), 8'h01);
        hs0 = hs_cnt;
        gesture_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("bp_one_handshake", 8'(hs_cnt - hs0), 8'h01);
        check("bp_drained", 8'(gesture_valid), 8'h00);

        // Reset with an event pending; strobe during reset is ignored
        gesture_ready = 1'b0;
        strobes(6, 100, 0, 0, 4);
        check("pre_rst_pending", 8'(gesture_valid), 8'h01);
        r_rstn = 1'b0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        r_rstn = 1'b1;
        check("rst_data",  gesture_data, 8'h00);
        check("rst_valid", 8'(gesture_valid), 8'h00);
        check("rst_level", gesture_level, 8'h3B);
        check("rst_ovf",   8'(overflow), 8'h00);

        // Warm-up restarts; back-to-back strobes
        gesture_ready = 1'b1;
        strobes(5, 100, 0, 0, 1);
        check("rewarm_no_event", 8'(gesture_valid), 8'h00);
        hs0 = hs_cnt;
        strobe(100, 0, 0, 4);
        check("rewarm_level", gesture_level, 8'h66);
        check("rewarm_handshake", 8'(hs_cnt - hs0), 8'h01);

        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
